hht_col_update: RTL and testbench

- Downstream compute stage of the HHT controller.
- Consumes the paired stream of Householder vector element v_i and column element x_i that the controller fetches from the v-value and column regions of memory.
- Buffers one VEC_LEN-element column and accumulates the dot product s = sum(v_i*x_i).
- Replays the buffered column as updated elements y_i = x_i - v_i*(s >>> SHIFT) on a valid/ready output stream, one column per pass.

---
 rtl/hht_pkg.sv | 21 ++
 rtl/hht_pair_buf.sv | 28 ++
 rtl/hht_col_update.sv | 142 ++++++++++++++
 tb/tb_hht_col_update.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hht_pkg.sv
// Shared types and default sizing for the HHT column-update stage.
// Holds the FSM state encoding and the buffered {v, x} pair layout.
package hht_pkg;

    localparam int DATA_W  = 32;
    localparam int VEC_LEN = 16;
    localparam int ACC_W   = 2*DATA_W + $clog2(VEC_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] v;
        logic signed [DATA_W-1:0] x;
    } pair_t;

endpackage

// File: rtl/hht_pair_buf.sv
// Column buffer for one pass of {v, x} pairs.
// Synchronous write, combinational read, no reset on the storage.
module hht_pair_buf
    import hht_pkg::*;
#(
    parameter int  DEPTH  = VEC_LEN,
    parameter int  AW     = $clog2(DEPTH),
    parameter type elem_t = pair_t
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  elem_t         wdata,
    input  logic [AW-1:0] raddr,
    output elem_t         rdata
);

    elem_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hht_col_update.sv
// HHT column update: buffers a column while accumulating s = sum(v*x), then
// replays y = x - v*(s >>> SHIFT) on a valid/ready stream, one column per pass.
module hht_col_update
    import hht_pkg::*;
#(
    parameter int DATA_W  = hht_pkg::DATA_W,
    parameter int VEC_LEN = hht_pkg::VEC_LEN,
    parameter int SHIFT   = 0,
    parameter int ACC_W   = 2*DATA_W + $clog2(VEC_LEN)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] v_data,
    input  logic signed [DATA_W-1:0] x_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y_data,
    output logic                     out_last,
    output logic                     done,
    output logic [15:0]              col_cnt,
    output logic                     busy
);

    localparam int AW = $clog2(VEC_LEN);
    localparam int IW = $clog2(VEC_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);
    localparam logic [IW-1:0] END_IDX  = IW'(VEC_LEN);

    typedef struct packed {
        logic signed [DATA_W-1:0] v;
        logic signed [DATA_W-1:0] x;
    } pair_w_t;

    function automatic logic signed [DATA_W-1:0] wrap_acc(input logic signed [ACC_W-1:0] val);
        return DATA_W'(val);
    endfunction

    function automatic logic signed [DATA_W-1:0] wrap_prod(input logic signed [2*DATA_W-1:0] val);
        return DATA_W'(val);
    endfunction

    state_t                     state_q, state_d;
    logic signed [ACC_W-1:0]    acc_p0, acc_sum;
    logic signed [2*DATA_W-1:0] in_prod, upd_prod;
    logic signed [DATA_W-1:0]   s_p1;
    logic [IW-1:0]              wr_idx, rd_idx;
    pair_w_t                    wr_pair, rd_pair;
    logic                       in_fire, out_fire, load_y, last_in;

    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_in  = in_fire && (state_q == ACCUM) && (wr_idx == LAST_IDX);
    assign load_y   = (state_q == UPDATE) && (!out_valid || out_ready) && (rd_idx < END_IDX);

    assign wr_pair  = '{v: v_data, x: x_data};
    assign in_prod  = v_data * x_data;
    assign acc_sum  = ((state_q == ACCUM) ? acc_p0 : '0)
                    + {{(ACC_W-2*DATA_W){in_prod[2*DATA_W-1]}}, in_prod};
    assign upd_prod = rd_pair.v * s_p1;

    hht_pair_buf #(
        .DEPTH  (VEC_LEN),
        .AW     (AW),
        .elem_t (pair_w_t)
    ) u_buf (
        .clk   (Clk),
        .we    (in_fire),
        .waddr (wr_idx[AW-1:0]),
        .wdata (wr_pair),
        .raddr (rd_idx[AW-1:0]),
        .rdata (rd_pair)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = ACCUM;
            ACCUM:   if (last_in) state_d = UPDATE;
            UPDATE:  if (out_fire && out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            col_cnt <= '0;
            wr_idx  <= '0;
            rd_idx  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DONE) begin
                col_cnt <= col_cnt + 16'd1;
                wr_idx  <= '0;
                rd_idx  <= '0;
            end else begin
                if (in_fire) wr_idx <= wr_idx + IW'(1);
                if (load_y)  rd_idx <= rd_idx + IW'(1);
            end
        end
    end

    // Accumulate stage -> scaled dot product latched with the final beat
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_p0 <= '0;
            s_p1   <= '0;
        end else begin
            if (state_q == DONE) begin
                acc_p0 <= '0;
            end else if (in_fire) begin
                acc_p0 <= acc_sum;
            end
            if (last_in) begin
                s_p1 <= wrap_acc(acc_sum >>> SHIFT);
            end
        end
    end

    // Output stage: holds y/valid/last steady while downstream stalls
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            y_data    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_y) begin
            y_data    <= rd_pair.x - wrap_prod(upd_prod);
            out_valid <= 1'b1;
            out_last  <= (rd_idx == LAST_IDX);
        end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hht_col_update.sv
// Scoreboard bench for hht_col_update: two instances (SHIFT=0 and SHIFT=4) share
// one stimulus stream; a wide-integer model predicts every y element.
module tb_hht_col_update;

    localparam int N = 16;

    typedef struct {
        logic [31:0] y0;
        logic [31:0] y4;
        logic        last;
    } exp_t;

    logic        clk, Rst, in_valid, out_ready;
    logic [31:0] v_data, x_data;
    logic        in_ready0, out_valid0, out_last0, done0, busy0;
    logic        in_ready4, out_valid4, out_last4, done4, busy4;
    logic [31:0] y0, y4;
    logic [15:0] col_cnt0, col_cnt4;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [31:0] cv[N], cx[N];
    int          rdy_mode = 0;
    int          exp_cols = 0;
    int          done_seen = 0;

    hht_col_update #(.SHIFT(0)) dut0 (
        .Clk(clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready0),
        .v_data(v_data), .x_data(x_data), .out_valid(out_valid0), .out_ready(out_ready),
        .y_data(y0), .out_last(out_last0), .done(done0), .col_cnt(col_cnt0), .busy(busy0)
    );

    hht_col_update #(.SHIFT(4)) dut4 (
        .Clk(clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready4),
        .v_data(v_data), .x_data(x_data), .out_valid(out_valid4), .out_ready(out_ready),
        .y_data(y4), .out_last(out_last4), .done(done4), .col_cnt(col_cnt4), .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: wide signed sum, arithmetic shift, then DATA_W wrap.
    function automatic logic [31:0] model_y(input int sh, input int i);
        logic signed [67:0] acc;
        logic signed [67:0] acc_sh;
        logic signed [31:0] s;
        logic signed [63:0] p;
        acc = '0;
        for (int j = 0; j < N; j++) acc += $signed(cv[j]) * $signed(cx[j]);
        acc_sh = acc >>> sh;
        s = acc_sh[31:0];
        p = $signed(cv[i]) * s;
        return cx[i] - p[31:0];
    endfunction

    task automatic push_column();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.y0 = model_y(0, i);
            e.y4 = model_y(4, i);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
        exp_cols++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
    task automatic send_column(input int gap, input int nbeats, input bit push);
        int t;
        if (push) push_column();
        for (int i = 0; i < nbeats; i++) begin
            in_valid = 1'b1;
            v_data = cv[i];
            x_data = cx[i];
            t = 0;
            @(negedge clk);
            while (!in_ready0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) chk("in_ready_wait", 0, 1);
            @(posedge clk); #1;
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                v_data = $urandom;
                x_data = $urandom;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
        chk("col_cnt0", col_cnt0, exp_cols);
        chk("col_cnt4", col_cnt4, exp_cols);
        chk("done_count", done_seen, exp_cols);
    endtask

    task automatic check_reset();
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_last", out_last0, 0);
        chk("rst_y", y0, 0);
        chk("rst_done", done0, 0);
        chk("rst_col_cnt", col_cnt0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_out_valid4", out_valid4, 0);
        chk("rst_col_cnt4", col_cnt4, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops expectations on each accepted output beat.
    initial begin
        exp_t e;
        bit          stall_p = 0;
        logic [31:0] stall_y = '0;
        logic        stall_last = 1'b0;
        bit          done_prev = 0;
        forever begin
            @(negedge clk);
            if (Rst) begin
                if (stall_p) begin
                    chk("stall_valid", out_valid0, 1);
                    chk("stall_y", y0, stall_y);
                    chk("stall_last", out_last0, stall_last);
                end
                stall_p = out_valid0 && !out_ready;
                stall_y = y0;
                stall_last = out_last0;
                if (out_valid0) chk("in_ready_update", in_ready0, 0);
                if (done0) begin
                    chk("in_ready_done", in_ready0, 0);
                    chk("done_width", done_prev, 0);
                    done_seen++;
                end
                done_prev = done0;
                if (out_valid0 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("y_shift0", y0, e.y0);
                        chk("last_shift0", out_last0, e.last);
                        chk("valid_shift4", out_valid4, 1);
                        chk("y_shift4", y4, e.y4);
                        chk("last_shift4", out_last4, e.last);
                    end
                end
            end else begin
                stall_p = 0;
                done_prev = 0;
            end
        end
    end

    initial begin
        Rst = 1'b0;
        in_valid = 1'b0;
        v_data = '0;
        x_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        Rst = 1'b1;
        @(posedge clk); #1;

        // Ramp column: y = i - 120 at SHIFT=0
        for (int i = 0; i < N; i++) begin cv[i] = 32'd1; cx[i] = i; end
        send_column(0, N, 1);
        wait_drain();

        // Constant column, first-output latency
        for (int i = 0; i < N; i++) begin cv[i] = 32'd2; cx[i] = 32'd8; end
        send_column(0, N, 1);
        @(negedge clk);
        chk("latency_pre", out_valid0, 0);
        @(negedge clk);
        chk("latency_first", out_valid0, 1);
        wait_drain();

        // Toggling in_valid with random stalls, back-to-back random columns
        rdy_mode = 1;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) begin cv[i] = $urandom; cx[i] = $urandom; end
            send_column(1, N, 1);
        end
        wait_drain();

        // Back-to-back fixed columns
        for (int i = 0; i < N; i++) begin cv[i] = 32'd1; cx[i] = 32'd1; end
        send_column(0, N, 1);
        for (int i = 0; i < N; i++) begin cv[i] = 32'd0; cx[i] = 32'd5; end
        send_column(0, N, 1);
        wait_drain();

        // Abort mid-pass with reset, then a fresh ramp column
        rdy_mode = 0;
        for (int i = 0; i < N; i++) begin cv[i] = 32'd1; cx[i] = i; end
        send_column(0, 9, 0);
        Rst = 1'b0;
        #1;
        check_reset();
        exp_cols = 0;
        done_seen = 0;
        @(posedge clk); #1;
        Rst = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_no_output", out_valid0, 0);
        chk("post_rst_no_done", done_seen, 0);
        send_column(0, N, 1);
        wait_drain();

        // Extreme operands: wrap of s and y
        for (int i = 0; i < N; i++) begin cv[i] = 32'h7FFF_FFFF; cx[i] = 32'h7FFF_FFFF; end
        send_column(0, N, 1);
        for (int i = 0; i < N; i++) begin cv[i] = 32'h8000_0000; cx[i] = 32'h7FFF_FFFF; end
        send_column(0, N, 1);
        wait_drain();

        // Random columns with random gaps and stalls
        rdy_mode = 1;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) begin cv[i] = $urandom; cx[i] = $urandom; end
            send_column(2, N, 1);
        end
        wait_drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
